// File: rtl/sparse_pkg.sv
// Shared types and constants for the sparse activation encoder:
// FSM state encoding, entry field layout and the frame length limit.
package sparse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ENTRY_W       = 16;
    localparam int FIELD_W       = 8;
    localparam int IDX_LSB       = 8;
    localparam int VAL_LSB       = 0;
    localparam int MAX_FRAME_LEN = 255;

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [FIELD_W-1:0] idx,
                                                    input logic [FIELD_W-1:0] val);
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[IDX_LSB +: FIELD_W] = idx;
        e[VAL_LSB +: FIELD_W] = val;
        return e;
    endfunction

endpackage

// File: rtl/sparse_encoder_if.sv
// Dense element stream into the encoder: valid/ready handshake with a
// frame-end marker.
interface sparse_encoder_if #(parameter int VAL_W = 8);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [VAL_W-1:0] in_data;
    logic                    in_last;

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/sparse_encoder_entry_packer.sv
// Pairs nonzero entries into two-lane buffer writes; a lone entry left at
// frame end is written on flush with lane 1 zeroed.
module entry_packer
    import sparse_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] entry,
    output logic [ENTRY_W-1:0] data_o0,
    output logic [ENTRY_W-1:0] data_o1,
    output logic               write_enable_o0,
    output logic               write_enable_o1,
    output logic [7:0]         wr_addr
);

    logic [ENTRY_W-1:0] hold;
    logic               hold_vld;
    logic [7:0]         pair_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold            <= '0;
            hold_vld        <= 1'b0;
            pair_cnt        <= '0;
            data_o0         <= '0;
            data_o1         <= '0;
            write_enable_o0 <= 1'b0;
            write_enable_o1 <= 1'b0;
            wr_addr         <= '0;
        end else begin
            write_enable_o0 <= 1'b0;
            write_enable_o1 <= 1'b0;
            if (clear) begin
                hold_vld <= 1'b0;
                pair_cnt <= '0;
                wr_addr  <= '0;
            end else if (push) begin
                if (hold_vld) begin
                    data_o0         <= hold;
                    data_o1         <= entry;
                    write_enable_o0 <= 1'b1;
                    write_enable_o1 <= 1'b1;
                    wr_addr         <= pair_cnt;
                    pair_cnt        <= pair_cnt + 8'd1;
                    hold_vld        <= 1'b0;
                end else begin
                    hold     <= entry;
                    hold_vld <= 1'b1;
                end
            end else if (flush && hold_vld) begin
                // Odd entry count: both strobes still fire so the buffer sees a whole pair slot.
                data_o0         <= hold;
                data_o1         <= '0;
                write_enable_o0 <= 1'b1;
                write_enable_o1 <= 1'b1;
                wr_addr         <= pair_cnt;
                pair_cnt        <= pair_cnt + 8'd1;
                hold_vld        <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sparse_encoder.sv
// Sparse activation encoder: turns a dense frame into {index,value} pairs.
// Optional SPARSE_ENC_THRESH_EN adds a magnitude threshold for the zero test.
module sparse_encoder
    import sparse_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int VAL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef SPARSE_ENC_THRESH_EN
    input  logic [6:0]         threshold,
`endif
    sparse_encoder_if.slave    bus,
    output logic [ENTRY_W-1:0] data_o0,
    output logic [ENTRY_W-1:0] data_o1,
    output logic               write_enable_o0,
    output logic               write_enable_o1,
    output logic [7:0]         wr_addr,
    output logic [7:0]         nz_count,
    output logic               done,
    output logic               overflow
);

    state_t           state;
    logic             ready_q;
    logic [IDX_W-1:0] elem_cnt;
    logic             accept;
    logic             is_nz;
    logic             start_ok;
    logic             at_limit;

    assign bus.in_ready = ready_q;
    assign accept       = bus.in_valid & ready_q;
    assign start_ok     = start & ((state == ST_IDLE) || (state == ST_DONE));
    assign at_limit     = (elem_cnt == IDX_W'(MAX_FRAME_LEN - 1));

`ifdef SPARSE_ENC_THRESH_EN
    logic [VAL_W:0] mag;
    // One extra bit so the most negative value has a representable magnitude.
    assign mag   = bus.in_data[VAL_W-1] ? -{bus.in_data[VAL_W-1], bus.in_data}
                                        :  {1'b0, bus.in_data};
    assign is_nz = (mag > (VAL_W+1)'(threshold));
`else
    assign is_nz = (bus.in_data != '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b0;
            elem_cnt <= '0;
            nz_count <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        ready_q  <= 1'b1;
                        elem_cnt <= '0;
                        nz_count <= '0;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + 1'b1;
                        if (is_nz) nz_count <= nz_count + 8'd1;
                        if (bus.in_last || at_limit) begin
                            state    <= ST_FLUSH;
                            ready_q  <= 1'b0;
                            overflow <= ~bus.in_last;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    entry_packer u_packer (
        .clk             (clk),
        .reset           (reset),
        .clear           (start_ok),
        .push            (accept & is_nz),
        .flush           (state == ST_FLUSH),
        .entry           (mk_entry(8'(elem_cnt), 8'(bus.in_data))),
        .data_o0         (data_o0),
        .data_o1         (data_o1),
        .write_enable_o0 (write_enable_o0),
        .write_enable_o1 (write_enable_o1),
        .wr_addr         (wr_addr)
    );

endmodule

// File: tb/tb_sparse_encoder.sv
// Directed bench for sparse_encoder: frames with hand-computed pair writes.
// Threshold frame is only exercised when SPARSE_ENC_THRESH_EN is defined.
module tb_sparse_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_o0, data_o1;
    logic        write_enable_o0, write_enable_o1;
    logic [7:0]  wr_addr, nz_count;
    logic        done, overflow;
`ifdef SPARSE_ENC_THRESH_EN
    logic [6:0]  threshold = 7'd0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [41:0] wr_log[$];
    logic [7:0]  fq[$];

    sparse_encoder_if #(.VAL_W(8)) bus ();

    sparse_encoder #(.IDX_W(8), .VAL_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
`ifdef SPARSE_ENC_THRESH_EN
        .threshold       (threshold),
`endif
        .bus             (bus),
        .data_o0         (data_o0),
        .data_o1         (data_o1),
        .write_enable_o0 (write_enable_o0),
        .write_enable_o1 (write_enable_o1),
        .wr_addr         (wr_addr),
        .nz_count        (nz_count),
        .done            (done),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Every strobed cycle is logged, so a strobe held for two cycles shows up as an extra write.
    always @(negedge clk)
        if (write_enable_o0 || write_enable_o1)
            wr_log.push_back({write_enable_o0, write_enable_o1, wr_addr, data_o0, data_o1});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] wr_exp(input logic [7:0] addr, input logic [15:0] e0,
                                           input logic [15:0] e1);
        return {2'b11, addr, e0, e1};
    endfunction

    function automatic logic [41:0] wr_at(input int i);
        return (wr_log.size() > i) ? wr_log[i] : '1;
    endfunction

    task automatic push_elem(input logic [7:0] v, input bit last);
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit with_last);
        for (int i = 0; i < fq.size(); i++)
            push_elem(fq[i], with_last && (i == fq.size() - 1));
    endtask

    task automatic do_start();
        wr_log.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_d0"}, 64'(data_o0), 64'd0);
        chk({tag, "_d1"}, 64'(data_o1), 64'd0);
        chk({tag, "_we"}, 64'({write_enable_o0, write_enable_o1}), 64'd0);
        chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_nz"}, 64'(nz_count), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // [0,5,0,-3,7]: pair (1,5)(3,-3) then padded (4,7).
        do_start();
        fq = '{8'h00, 8'h05, 8'h00, 8'hFD, 8'h07};
        send_frame(1);
        wait_done("s1_done");
        chk("s1_nwr", 64'(wr_log.size()), 64'd2);
        chk("s1_w0", 64'(wr_at(0)), 64'(wr_exp(8'h00, 16'h0105, 16'h03FD)));
        chk("s1_w1", 64'(wr_at(1)), 64'(wr_exp(8'h01, 16'h0407, 16'h0000)));
        chk("s1_nz", 64'(nz_count), 64'd3);
        chk("s1_ovf", 64'(overflow), 64'd0);
        repeat (3) @(negedge clk);
        chk("s1_done_held", 64'(done), 64'd1);
        chk("s1_rdy_low", 64'(bus.in_ready), 64'd0);

        // All-zero frame from DONE.
        do_start();
        chk("s2_done_clr", 64'(done), 64'd0);
        fq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(1);
        wait_done("s2_done");
        chk("s2_nwr", 64'(wr_log.size()), 64'd0);
        chk("s2_nz", 64'(nz_count), 64'd0);

        // 255 nonzero elements, value = index+1, no in_last.
        do_start();
        fq.delete();
        for (int i = 0; i < 255; i++) fq.push_back(8'(i + 1));
        send_frame(0);
        wait_done("s3_done");
        chk("s3_ovf", 64'(overflow), 64'd1);
        chk("s3_nz", 64'(nz_count), 64'd255);
        chk("s3_nwr", 64'(wr_log.size()), 64'd128);
        for (int k = 0; k < 127; k++)
            chk($sformatf("s3_w%0d", k), 64'(wr_at(k)),
                64'(wr_exp(8'(k), {8'(2*k), 8'(2*k+1)}, {8'(2*k+1), 8'(2*k+2)})));
        chk("s3_wlast", 64'(wr_at(127)), 64'(wr_exp(8'd127, 16'hFEFF, 16'h0000)));

        // Reset mid-frame after 3 elements, then a clean frame.
        do_start();
        chk("s4_ovf_clr", 64'(overflow), 64'd0);
        fq = '{8'h01, 8'h02, 8'h03};
        send_frame(0);
        reset = 1'b1;
        @(negedge clk);
        chk_zero_outputs("s4_rst");
        reset = 1'b0;
        @(negedge clk);
        chk("s4_idle_rdy", 64'(bus.in_ready), 64'd0);
        do_start();
        fq = '{8'h00, 8'h04, 8'h06};
        send_frame(1);
        wait_done("s4_done");
        chk("s4_nwr", 64'(wr_log.size()), 64'd1);
        chk("s4_w0", 64'(wr_at(0)), 64'(wr_exp(8'h00, 16'h0104, 16'h0206)));
        chk("s4_nz", 64'(nz_count), 64'd2);

        // Toggling in_valid; a start pulse mid-frame must be ignored.
        do_start();
        push_elem(8'h01, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push_elem(8'h02, 1);
        wait_done("s5_done");
        chk("s5_nwr", 64'(wr_log.size()), 64'd1);
        chk("s5_w0", 64'(wr_at(0)), 64'(wr_exp(8'h00, 16'h0001, 16'h0102)));
        chk("s5_nz", 64'(nz_count), 64'd2);

`ifdef SPARSE_ENC_THRESH_EN
        threshold = 7'd4;
        do_start();
        fq = '{8'h03, 8'hFC, 8'h05, 8'hF7};
        send_frame(1);
        wait_done("s6_done");
        chk("s6_nwr", 64'(wr_log.size()), 64'd1);
        chk("s6_w0", 64'(wr_at(0)), 64'(wr_exp(8'h00, 16'h0205, 16'h03F7)));
        chk("s6_nz", 64'(nz_count), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
